// File: rtl/add_accum.sv
// Block accumulator behind the adder stage: sums ACC_LEN accepted samples
// into a saturating BIT_ACC-wide total and hands it off on a valid/ready port.
module add_accum #(
    parameter int unsigned BIT_IN  = 28,
    parameter int unsigned BIT_ACC = 32,
    parameter int unsigned ACC_LEN = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BIT_IN-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BIT_ACC-1:0] out_data,
    output logic               out_sat,
    output logic               busy
);

    localparam int unsigned CW = $clog2(ACC_LEN + 1);
    localparam int unsigned SW = BIT_ACC + 1;
    localparam logic [CW-1:0] LAST = CW'(ACC_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [BIT_ACC-1:0] acc, acc_nxt, out_data_nxt;
    logic [CW-1:0]      count, count_nxt;
    logic               sat, sat_nxt;
    logic               out_valid_nxt, out_sat_nxt, in_ready_nxt, busy_nxt;
    logic [SW-1:0]      sum;
    logic               accept;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            count     <= count_nxt;
            sat       <= sat_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
            out_sat   <= out_sat_nxt;
            in_ready  <= in_ready_nxt;
            busy      <= busy_nxt;
        end
    end

    // Next-state, accumulate/clamp and handshake logic
    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        count_nxt     = count;
        sat_nxt       = sat;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;
        out_sat_nxt   = out_sat;

        // One extra bit: the carry out is exactly the "exceeds all-ones" test
        sum    = {1'b0, acc} + SW'(in_data);
        accept = in_valid && in_ready;

        if (clear) begin
            state_nxt     = IDLE;
            acc_nxt       = '0;
            count_nxt     = '0;
            sat_nxt       = 1'b0;
            out_valid_nxt = 1'b0;
            out_sat_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (accept) begin
                        if (sum[BIT_ACC]) begin
                            acc_nxt = '1;
                            sat_nxt = 1'b1;
                        end else begin
                            acc_nxt = sum[BIT_ACC-1:0];
                        end
                        count_nxt = count + CW'(1);
                        if (count_nxt == LAST) begin
                            state_nxt     = HOLD;
                            out_valid_nxt = 1'b1;
                            out_data_nxt  = acc_nxt;
                            out_sat_nxt   = sat_nxt;
                        end else begin
                            state_nxt = ACC;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_nxt     = IDLE;
                        acc_nxt       = '0;
                        count_nxt     = '0;
                        sat_nxt       = 1'b0;
                        out_valid_nxt = 1'b0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        in_ready_nxt = (state_nxt != HOLD);
        busy_nxt     = (state_nxt == ACC);
    end

endmodule

// File: tb/tb_add_accum.sv
// Randomized and directed bench for add_accum: four parameterizations share
// one stimulus stream and are each compared to a block-sum reference model.
module tb_add_accum;

    localparam int NI = 4;
    localparam int unsigned BI [NI] = '{28, 28, 8, 28};
    localparam int unsigned BA [NI] = '{32, 29, 8, 30};
    localparam int unsigned LN [NI] = '{4, 3, 1, 4};
    localparam logic [27:0] MAX28 = 28'hFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear, in_valid, out_ready;
    logic [27:0] in_data;

    logic        ov [NI];
    logic        ir [NI];
    logic        os [NI];
    logic        bz [NI];
    logic [31:0] od [NI];

    logic [31:0] od0;
    logic [28:0] od1;
    logic [7:0]  od2;
    logic [29:0] od3;

    int n_checks = 0;
    int n_fail   = 0;

    bit     pend  [NI];
    int     cnt   [NI];
    longint total [NI];
    longint mdata [NI];
    bit     msat  [NI];

    always #5 clk = ~clk;

    add_accum #(.BIT_IN(28), .BIT_ACC(32), .ACC_LEN(4)) u0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od0),
        .out_sat(os[0]), .busy(bz[0]));
    add_accum #(.BIT_IN(28), .BIT_ACC(29), .ACC_LEN(3)) u1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od1),
        .out_sat(os[1]), .busy(bz[1]));
    add_accum #(.BIT_IN(8), .BIT_ACC(8), .ACC_LEN(1)) u2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(ir[2]),
        .in_data(in_data[7:0]), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od2),
        .out_sat(os[2]), .busy(bz[2]));
    add_accum #(.BIT_IN(28), .BIT_ACC(30), .ACC_LEN(4)) u3 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(ir[3]),
        .in_data(in_data), .out_valid(ov[3]), .out_ready(out_ready), .out_data(od3),
        .out_sat(os[3]), .busy(bz[3]));

    assign od[0] = od0;
    assign od[1] = 32'(od1);
    assign od[2] = 32'(od2);
    assign od[3] = 32'(od3);

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NI; i++) begin
            pend[i] = 1'b0; cnt[i] = 0; total[i] = 0; mdata[i] = 0; msat[i] = 1'b0;
        end
    endfunction

    // Block-level reference: plain sum of the block, clamped once at the end
    function automatic void model_edge();
        for (int i = 0; i < NI; i++) begin
            longint mx = (longint'(1) << BA[i]) - 1;
            longint x  = longint'(in_data) & ((longint'(1) << BI[i]) - 1);
            if (clear) begin
                pend[i] = 1'b0; cnt[i] = 0; total[i] = 0; msat[i] = 1'b0;
            end else if (pend[i]) begin
                if (out_ready) begin
                    pend[i] = 1'b0; cnt[i] = 0; total[i] = 0;
                end
            end else if (in_valid) begin
                total[i] += x;
                cnt[i]++;
                if (cnt[i] == int'(LN[i])) begin
                    pend[i]  = 1'b1;
                    msat[i]  = total[i] > mx;
                    mdata[i] = msat[i] ? mx : total[i];
                end
            end
        end
    endfunction

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("out_valid[%0d]", i), longint'(ov[i]), longint'(pend[i]));
            check($sformatf("in_ready[%0d]", i), longint'(ir[i]), longint'(!pend[i]));
            check($sformatf("busy[%0d]", i), longint'(bz[i]), longint'(!pend[i] && cnt[i] > 0));
            check($sformatf("out_data[%0d]", i), longint'(od[i]), mdata[i]);
            check($sformatf("out_sat[%0d]", i), longint'(os[i]), longint'(msat[i]));
        end
    endtask

    task automatic step(input bit v, input logic [27:0] d, input bit c, input bit r);
        in_valid = v; in_data = d; clear = c; out_ready = r;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        @(negedge clk);
    endtask

    // Assert reset between clock edges and check outputs before any edge
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        model_reset();
        @(negedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Basic block of 1,2,3,4
        for (int k = 1; k <= 4; k++) step(1'b1, 28'(k), 1'b0, 1'b1);
        check("sum10", longint'(od[0]), 10);
        check("sum10_valid", longint'(ov[0]), 1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("after_hs_valid", longint'(ov[0]), 0);
        check("after_hs_ready", longint'(ir[0]), 1);

        // Saturation boundary, then backpressure
        async_reset();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, MAX28, 1'b0, 1'b0);
            if (k == 2) begin
                check("sat29_data", longint'(od[1]), (longint'(1) << 29) - 1);
                check("sat29_flag", longint'(os[1]), 1);
            end
        end
        check("nosat30_data", longint'(od[3]), (longint'(1) << 30) - 4);
        check("nosat30_flag", longint'(os[3]), 0);
        for (int k = 0; k < 5; k++) step(1'b1, 28'(k + 50), 1'b0, 1'b0);
        check("bp_hold_data", longint'(od[0]), (longint'(1) << 30) - 4);
        check("bp_ready_low", longint'(ir[0]), 0);
        step(1'b1, 28'd9, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b1, 28'd2, 1'b0, 1'b0);
        check("fresh_block", longint'(od[0]), 8);

        // Gaps: 5,_,_,7,_,9
        async_reset();
        step(1'b1, 28'd5, 1'b0, 1'b0);
        check("gap_busy", longint'(bz[1]), 1);
        step(1'b0, 28'd99, 1'b0, 1'b0);
        step(1'b0, 28'd99, 1'b0, 1'b0);
        step(1'b1, 28'd7, 1'b0, 1'b0);
        step(1'b0, 28'd99, 1'b0, 1'b0);
        step(1'b1, 28'd9, 1'b0, 1'b0);
        check("gap_sum", longint'(od[1]), 21);
        check("gap_busy_hold", longint'(bz[1]), 0);

        // Clear mid-block, then clear while holding
        async_reset();
        step(1'b1, 28'd100, 1'b0, 1'b0);
        step(1'b1, 28'd200, 1'b0, 1'b0);
        step(1'b1, 28'd300, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, 28'd1, 1'b0, 1'b0);
        check("clear_sum", longint'(od[0]), 4);
        step(1'b1, 28'd5, 1'b1, 1'b1);
        check("clear_hold_valid", longint'(ov[0]), 0);
        step(1'b0, '0, 1'b0, 1'b1);

        // Asynchronous reset mid-block
        step(1'b1, 28'd40, 1'b0, 1'b1);
        step(1'b1, 28'd40, 1'b0, 1'b1);
        async_reset();
        check("rst_busy", longint'(bz[0]), 0);
        for (int k = 0; k < 4; k++) step(1'b1, 28'd3, 1'b0, 1'b1);
        check("rst_sum", longint'(od[0]), 12);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            logic [27:0] d;
            case ($urandom_range(0, 3))
                0:       d = MAX28;
                1:       d = 28'($urandom);
                default: d = 28'($urandom_range(0, 300));
            endcase
            if ($urandom_range(0, 499) == 0) async_reset();
            step($urandom_range(0, 9) < 7, d, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 9) < 6);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
